// File: rtl/raster_scan_gen_pkg.sv
// Shared types for the raster scan generator: FSM state and scan direction.
// Used by raster_scan_gen and raster_axis_counter.
package raster_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/raster_scan_gen_axis_counter.sv
// One axis of the raster: counts 0..LIMIT-1 and wraps to its line start.
// Down-counting exists only when RASTER_SERPENTINE_EN is defined.
module raster_axis_counter
    import raster_pkg::*;
#(
    parameter int W     = 4,
    parameter int LIMIT = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    input  dir_t         dir,
    output logic [W-1:0] cnt,
    output logic         at_end
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

`ifdef RASTER_SERPENTINE_EN
    assign at_end = (dir == DIR_DOWN) ? (cnt == '0) : (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (dir == DIR_DOWN) begin
                cnt <= at_end ? LAST : cnt - 1'b1;
            end else begin
                cnt <= at_end ? '0 : cnt + 1'b1;
            end
        end
    end
`else
    logic unused_dir;
    assign unused_dir = (dir == DIR_DOWN);

    assign at_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/raster_scan_gen.sv
// Raster (x,y) coordinate generator with valid/ready handshake and line/frame markers.
// Optional serpentine scan order when RASTER_SERPENTINE_EN is defined.
module raster_scan_gen
    import raster_pkg::*;
#(
    parameter int XW     = 4,
    parameter int YW     = 4,
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cont,
    input  logic          ready,
    output logic          valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sol,
    output logic          eol,
    output logic          sof,
    output logic          eof,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);

    state_t state;
    dir_t   x_dir;
    logic   accept;
    logic   x_end;
    logic   y_end;
    logic   x_first;
    logic   frame_last;
    logic   x_inc;
    logic   y_inc;
    logic   clr;

    assign valid      = (state == SCAN);
    assign busy       = (state == SCAN);
    assign accept     = valid && ready;
    assign frame_last = x_end && y_end;

`ifdef RASTER_SERPENTINE_EN
    // Odd rows run right-to-left; x parks at the line end while y steps.
    assign x_dir   = y[0] ? DIR_DOWN : DIR_UP;
    assign x_inc   = accept && !x_end;
    assign x_first = (x_dir == DIR_DOWN) ? (x == XLAST) : (x == '0);
`else
    assign x_dir   = DIR_UP;
    assign x_inc   = accept;
    assign x_first = (x == '0);
`endif

    assign y_inc = accept && x_end;
    assign clr   = reset || (state == IDLE) || (accept && frame_last);

    raster_axis_counter #(
        .W     (XW),
        .LIMIT (WIDTH)
    ) u_x (
        .clk    (clk),
        .inc    (x_inc),
        .clr    (clr),
        .dir    (x_dir),
        .cnt    (x),
        .at_end (x_end)
    );

    raster_axis_counter #(
        .W     (YW),
        .LIMIT (HEIGHT)
    ) u_y (
        .clk    (clk),
        .inc    (y_inc),
        .clr    (clr),
        .dir    (DIR_UP),
        .cnt    (y),
        .at_end (y_end)
    );

    assign sol = valid && x_first;
    assign eol = valid && x_end;
    assign sof = valid && (x == '0) && (y == '0);
    assign eof = valid && frame_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && frame_last;
            case (state)
                IDLE: if (start) state <= SCAN;
                SCAN: if (accept && frame_last && !cont) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scan_gen.sv
// Scoreboard bench for raster_scan_gen: 4xH frame instance plus a 1x1 instance.
// Expected order follows RASTER_SERPENTINE_EN when that macro is defined.
module tb_raster_scan_gen;

`ifdef RASTER_SERPENTINE_EN
    localparam int H0 = 2;
`else
    localparam int H0 = 3;
`endif
    localparam int W0 = 4;

    typedef struct {
        int x;
        int y;
        bit sol;
        bit eol;
        bit sof;
        bit eof;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, cont0, ready0;
    logic       valid0, sol0, eol0, sof0, eof0, fd0, busy0;
    logic [3:0] x0, y0;
    logic       start1, cont1, ready1;
    logic       valid1, sol1, eol1, sof1, eof1, fd1, busy1;
    logic [0:0] x1, y1;

    pix_t sb[$];
    int   tests    = 0;
    int   failed   = 0;
    int   fd_count = 0;
    bit   m_scan   = 1'b0;

    always #5 clk = ~clk;

    raster_scan_gen #(.XW(4), .YW(4), .WIDTH(W0), .HEIGHT(H0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .cont(cont0), .ready(ready0),
        .valid(valid0), .x(x0), .y(y0), .sol(sol0), .eol(eol0), .sof(sof0),
        .eof(eof0), .frame_done(fd0), .busy(busy0)
    );

    raster_scan_gen #(.XW(1), .YW(1), .WIDTH(1), .HEIGHT(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .cont(cont1), .ready(ready1),
        .valid(valid1), .x(x1), .y(y1), .sol(sol1), .eol(eol1), .sof(sof1),
        .eof(eof1), .frame_done(fd1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                pix_t p;
                p.x = c;
`ifdef RASTER_SERPENTINE_EN
                if (r % 2 == 1) p.x = w - 1 - c;
`endif
                p.y   = r;
                p.sol = (c == 0);
                p.eol = (c == w - 1);
                p.sof = (r == 0) && (c == 0);
                p.eof = (r == h - 1) && (c == w - 1);
                sb.push_back(p);
            end
        end
    endtask

    // One clock of u0: model the handshake, then compare against the scoreboard head.
    task automatic tick();
        bit acc, exp_fd, rst, nxt_scan;
        rst      = reset;
        acc      = 1'b0;
        exp_fd   = 1'b0;
        nxt_scan = m_scan;
        if (m_scan && ready0 && sb.size() > 0) begin
            acc    = 1'b1;
            exp_fd = sb[0].eof;
            if (sb[0].eof && !cont0) nxt_scan = 1'b0;
        end
        if (!m_scan && start0) nxt_scan = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_scan = 1'b0;
            return;
        end
        m_scan = nxt_scan;
        if (acc) void'(sb.pop_front());
        if (fd0) fd_count++;
        chk("frame_done", fd0, exp_fd);
        chk("valid", valid0, m_scan);
        chk("busy", busy0, m_scan);
        if (valid0 && sb.size() > 0) begin
            chk("x", x0, sb[0].x);
            chk("y", y0, sb[0].y);
            chk("sol", sol0, sb[0].sol);
            chk("eol", eol0, sb[0].eol);
            chk("sof", sof0, sb[0].sof);
            chk("eof", eof0, sb[0].eof);
        end else if (!valid0) begin
            chk("markers_idle", {sol0, eol0, sof0, eof0}, 4'b0000);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int fd_before;
        int n;
        bit [3:0] pat;
        pat    = 4'b1001;
        reset  = 1'b1;
        start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b1;
        start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_x", x0, 0);
        chk("rst_y", y0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_fd", fd0, 0);
        chk("rst_markers", {sol0, eol0, sof0, eof0}, 4'b0000);
        chk("rst_valid1", valid1, 0);

        // Single frame, ready always high.
        push_frame(W0, H0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        drain("frame1_drain", 100);
        tick();
        chk("frame1_idle_valid", valid0, 0);
        chk("frame1_idle_busy", busy0, 0);

        // Back-pressure with ready pattern 1,0,0,1.
        push_frame(W0, H0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            ready0 = pat[n % 4];
            tick();
            n++;
        end
        chk("bp_drain", sb.size(), 0);
        ready0 = 1'b1;
        tick();

        // Two back-to-back frames with cont=1 on the first.
        fd_before = fd_count;
        push_frame(W0, H0);
        push_frame(W0, H0);
        cont0  = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (sb.size() > W0 * H0 && n < 100) begin
            tick();
            n++;
        end
        chk("cont_first_frame", sb.size(), W0 * H0);
        cont0 = 1'b0;
        drain("cont_drain", 100);
        tick();
        chk("cont_fd_count", fd_count - fd_before, 2);

        // Reset in the middle of a frame at (2,1).
        push_frame(W0, H0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (sb.size() > 0 && !(sb[0].x == 2 && sb[0].y == 1) && n < 100) begin
            tick();
            n++;
        end
        chk("mid_x", x0, 2);
        chk("mid_y", y0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_x", x0, 0);
        chk("mid_rst_y", y0, 0);
        chk("mid_rst_valid", valid0, 0);
        chk("mid_rst_busy", busy0, 0);
        tick();
        chk("mid_rst_fd", fd0, 0);
        push_frame(W0, H0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        drain("restart_drain", 100);

        // 1x1 frame: every marker on the single pixel.
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("one_valid", valid1, 1);
        chk("one_x", x1, 0);
        chk("one_y", y1, 0);
        chk("one_markers", {sol1, eol1, sof1, eof1}, 4'b1111);
        @(posedge clk);
        #1;
        chk("one_fd", fd1, 1);
        chk("one_valid_after", valid1, 0);
        chk("one_busy_after", busy1, 0);
        @(posedge clk);
        #1;
        chk("one_fd_pulse", fd1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/raster_scan_gen.md
Name: raster_scan_gen

Overview:
- Parametrised successor to the fixed 16x16 raster counter.
- Generates (x,y) pixel coordinates over a configurable WIDTH x HEIGHT frame.
- Adds start/continuous control, valid/ready back-pressure and start/end-of-line/frame markers.
- Feeds the pixel pipeline; the downstream stage consumes one coordinate per accepted handshake.

Parameters:
- XW, 4, bit width of x output
- YW, 4, bit width of y output
- WIDTH, 16, pixels per line; legal range 1..2**XW
- HEIGHT, 16, lines per frame; legal range 1..2**YW

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame when IDLE; ignored in SCAN
- cont  in  1  sampled on last-pixel acceptance: 1 = wrap into next frame, 0 = return to IDLE
- ready  in  1  downstream accepts current coordinate
- valid  out  1  x/y hold a valid coordinate
- x  out  XW  column
- y  out  YW  row
- sol  out  1  valid && first pixel of line
- eol  out  1  valid && last pixel of line
- sof  out  1  valid && first pixel of frame
- eof  out  1  valid && last pixel of frame
- frame_done  out  1  one-cycle pulse, cycle after eof pixel accepted
- busy  out  1  state==SCAN

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, x=0, y=0, valid=0, frame_done=0. All markers are 0 because they are gated by valid.
- Mid-frame reset: reset has priority over every other input. Any frame in progress is abandoned at the next edge.
- IDLE:
  - valid=0; x and y hold 0.
  - start=1 -> SCAN at next edge, with x=0, y=0, valid=1. First coordinate is visible one cycle after start.
- SCAN:
  - valid=1 throughout.
  - accept = valid && ready. No accept: x, y and markers hold stable. ready may toggle freely.
  - On accept, not end of line: x advances one position.
  - On accept, end of line, not end of frame: x returns to line start, y=y+1.
  - On accept of last pixel: frame_done=1 next cycle.
    - cont=1: x=0, y=0, stay in SCAN. No bubble: the next frame's sof is presented the following cycle.
    - cont=0: go to IDLE, valid=0.
- Markers: sol, eol, sof and eof are combinational from registered x, y and valid; zero-cycle latency relative to coordinate.
- WIDTH=1: sol and eol are both asserted on every pixel.
- HEIGHT=1: sof implies y=0 and eof occurs on the same line.
- WIDTH=HEIGHT=1: sof, eof, sol and eol all high together.
- Comparisons use the full XW/YW width. No wrap past WIDTH-1 or HEIGHT-1 may ever appear on x/y.
- start asserted in the same cycle IDLE is re-entered is not seen. start is only sampled while in IDLE.
- Throughput: one coordinate per cycle while ready=1.

Optional Feature:
- Macro: RASTER_SERPENTINE_EN.
- Defined (serpentine scan):
  - Even rows (y[0]=0) scan x from 0 up to WIDTH-1; odd rows scan from WIDTH-1 down to 0.
  - The row change keeps x at the line-end value; the new row starts at that column.
  - sol/eol follow scan direction.
  - eof is at x=WIDTH-1 if HEIGHT odd, x=0 if HEIGHT even.
  - On wrap or start, x=0, y=0.
- Undefined: every row scans left-to-right. No down-count logic is synthesised.

Decomposition:
- Package raster_pkg:
  - state enum {IDLE, SCAN}
  - scan-direction typedef {DIR_UP, DIR_DOWN}
- Sub-module raster_axis_counter, instantiated for x and y:
  - Parameters W and LIMIT; inputs inc, clr, dir.
  - Outputs cnt and at_end; at_end is direction-aware.
- Top level holds the FSM, handshake and marker logic.

Test Plan:
- WIDTH=4, HEIGHT=3, ready=1, cont=0; pulse start -> 12 coordinates (0,0),(1,0)..(3,2) on consecutive cycles; sof at (0,0); eol at x=3 for each row; eof at (3,2); frame_done one cycle later; then valid=0 and busy=0.
- Same config with ready toggled 1,0,0,1 repeating -> x/y and markers stable while ready=0; identical 12-coordinate sequence; no skips or duplicates.
- cont=1 across two frames -> after (3,2) is accepted, (0,0) with sof appears on the very next cycle; frame_done pulses once per frame.
- Reset asserted for one cycle at (2,1) mid-frame -> next cycle x=0, y=0, valid=0, IDLE; a later start restarts cleanly at (0,0).
- WIDTH=1, HEIGHT=1; start -> single pixel (0,0) with sof, eof, sol and eol all 1; then frame_done.
- With RASTER_SERPENTINE_EN, WIDTH=4, HEIGHT=2 -> sequence (0,0)(1,0)(2,0)(3,0)(3,1)(2,1)(1,1)(0,1); eof at (0,1); eol at (3,0) and (0,1).
